// File: rtl/win_gen3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window per channel.
// Optional output register stage enabled by defining WIN_GEN_OUTREG_EN.

module win_gen3x3_lane (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_acc,
  input  logic [9:0]  i_r0,
  input  logic [9:0]  i_r1,
  input  logic [9:0]  i_r2,
  output logic [89:0] o_win
);
  logic [89:0]     win_q, win_d;
  logic [2:0][9:0] col_new;

  assign col_new = {i_r2, i_r1, i_r0};

  // Each window row shifts toward col 0; the fresh column enters at col 2.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[30*r +: 10]      = win_q[30*r + 10 +: 10];
      win_d[30*r + 10 +: 10] = win_q[30*r + 20 +: 10];
      win_d[30*r + 20 +: 10] = col_new[r];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      win_q <= '0;
    else if (i_acc) win_q <= win_d;
  end

  assign o_win = win_q;
endmodule

module win_gen3x3 #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [29:0] i_data,
  output logic [89:0] o_busData0,
  output logic [89:0] o_busData1,
  output logic [89:0] o_busData2,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_busy,
  output logic        o_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            acc, col_end, row_end;
  logic            vld_q, last_q, done_w;
  logic [29:0]     lb0_q [IMG_W];
  logic [29:0]     lb1_q [IMG_W];
  logic [29:0]     lb0_rd, lb1_rd;
  logic [2:0][89:0] win;

  assign acc     = i_valid && (state_q == FILL || state_q == RUN);
  assign col_end = (col_q == CW'(IMG_W - 1));
  assign row_end = (row_q == RW'(IMG_H - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = FILL;
        col_d   = '0;
        row_d   = '0;
      end
      FILL: if (acc && col_end && row_q == RW'(1)) state_d = RUN;
      RUN:  if (acc && col_end && row_end) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (acc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= acc && row_q >= RW'(2) && col_q >= CW'(2);
      last_q  <= acc && row_end && col_end;
    end
  end

  // Line buffers are never reset; output gating keeps stale rows from being emitted.
  always_ff @(posedge i_clk) begin
    if (acc) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= i_data;
    end
  end

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];

  for (genvar ch = 0; ch < 3; ch++) begin : g_lane
    win_gen3x3_lane u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_acc (acc),
      .i_r0  (lb0_rd[10*ch +: 10]),
      .i_r1  (lb1_rd[10*ch +: 10]),
      .i_r2  (i_data[10*ch +: 10]),
      .o_win (win[ch])
    );
  end

  assign done_w = (state_q == DONE);
  assign o_busy = (state_q == FILL) || (state_q == RUN);

`ifdef WIN_GEN_OUTREG_EN
  logic [2:0][89:0] bus_q;
  logic             vld_o_q, last_o_q, done_o_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus_q    <= '0;
      vld_o_q  <= 1'b0;
      last_o_q <= 1'b0;
      done_o_q <= 1'b0;
    end else begin
      bus_q    <= win;
      vld_o_q  <= vld_q;
      last_o_q <= last_q;
      done_o_q <= done_w;
    end
  end

  assign o_busData0 = bus_q[0];
  assign o_busData1 = bus_q[1];
  assign o_busData2 = bus_q[2];
  assign o_valid    = vld_o_q;
  assign o_last     = last_o_q;
  assign o_done     = done_o_q;
`else
  assign o_busData0 = win[0];
  assign o_busData1 = win[1];
  assign o_busData2 = win[2];
  assign o_valid    = vld_q;
  assign o_last     = last_q;
  assign o_done     = done_w;
`endif
endmodule

// File: tb/tb_win_gen3x3.sv
// Scoreboard bench for win_gen3x3: random frames vs an image-array reference model.
module tb_win_gen3x3;
  localparam int W = 4;
  localparam int H = 4;
`ifdef WIN_GEN_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [2:0][89:0] b;
    bit               last;
    int               edge_n;
  } exp_t;

  logic        clk, i_rst, i_start, i_valid;
  logic [29:0] i_data;
  logic [89:0] o_busData0, o_busData1, o_busData2;
  logic        o_valid, o_last, o_busy, o_done;

  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  exp_t q[$];
  bit   acc_at[int];

  win_gen3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .o_busData0(o_busData0), .o_busData1(o_busData1), .o_busData2(o_busData2),
    .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [89:0] got, input logic [89:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 90'(o_valid), 90'd0);
    chk({tag, "_last"},  90'(o_last),  90'd0);
    chk({tag, "_done"},  90'(o_done),  90'd0);
    chk({tag, "_busy"},  90'(o_busy),  90'd0);
    chk({tag, "_bus0"},  o_busData0, 90'd0);
    chk({tag, "_bus1"},  o_busData1, 90'd0);
    chk({tag, "_bus2"},  o_busData2, 90'd0);
  endtask

  // Monitor: pops one expected window per o_valid, checks timing, gaps and bus hold.
  exp_t             m_e;
  logic [2:0][89:0] prev_bus;
  bit               have_prev = 0;
  bit               prev_rst  = 1;
  always @(negedge clk) begin
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 90'(o_valid), 90'd0);
      end else begin
        m_e = q.pop_front();
        chk("latency", 90'(edges), 90'(m_e.edge_n));
        chk("bus0", o_busData0, m_e.b[0]);
        chk("bus1", o_busData1, m_e.b[1]);
        chk("bus2", o_busData2, m_e.b[2]);
        chk("last", 90'(o_last), 90'(m_e.last));
        chk("done", 90'(o_done), 90'(m_e.last));
      end
    end else begin
      if (q.size() > 0 && q[0].edge_n < edges) begin
        checks++;
        errors++;
        $display("FAIL missing_window got=none exp_edge=%0d now=%0d", q[0].edge_n, edges);
        void'(q.pop_front());
      end
      chk("done_without_valid", 90'(o_done), 90'd0);
    end
    if (have_prev && !prev_rst && !acc_at.exists(edges - LAT)) begin
      chk("hold0", o_busData0, prev_bus[0]);
      chk("hold1", o_busData1, prev_bus[1]);
      chk("hold2", o_busData2, prev_bus[2]);
    end
    prev_bus  = {o_busData2, o_busData1, o_busData0};
    have_prev = 1;
    prev_rst  = i_rst;
  end

  // gap: 0 none, 1 one idle cycle between pixels, 2 random idle cycles.
  task automatic do_frame(input int patt, input int gap, input int abort_at, input bit start_mid);
    logic [29:0] img [W*H];
    exp_t        e;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_fill", 90'(o_busy), 90'd1);
    for (int p = 0; p < W*H; p++) begin
      int r = p / W;
      int c = p % W;
      if (p > 0 && (gap == 1 || (gap == 2 && $urandom_range(2) == 0))) begin
        i_valid = 1'b0;
        i_data  = 30'($urandom);
        tick();
      end
      img[p]  = (patt == 0) ? {10'(p + 200), 10'(p + 100), 10'(p)} : 30'($urandom);
      i_data  = img[p];
      i_valid = 1'b1;
      i_start = start_mid && (p == 2*W + 1);
      acc_at[edges + 1] = 1'b1;
      if (r >= 2 && c >= 2) begin
        for (int ch = 0; ch < 3; ch++)
          for (int k = 0; k < 9; k++)
            e.b[ch][10*k +: 10] = img[(r - 2 + k/3)*W + (c - 2 + k%3)][10*ch +: 10];
        e.last   = (p == W*H - 1);
        e.edge_n = edges + 1 + LAT;
        q.push_back(e);
      end
      if (p == W*H - 1) chk("busy_run", 90'(o_busy), 90'd1);
      tick();
      i_start = 1'b0;
      if (abort_at == p) begin
        i_valid = 1'b0;
        i_rst   = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_zero("abort");
        return;
      end
    end
    i_valid = 1'b0;
    chk("busy_after_last", 90'(o_busy), 90'd0);
    tick();
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    tick();
    tick();
    i_rst = 1'b0;
    chk_zero("reset");

    do_frame(0, 0, -1, 1'b0);
    do_frame(0, 1, -1, 1'b0);
    do_frame(1, 2, -1, 1'b0);

    do_frame(1, 0, 9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1;
      i_data  = 30'($urandom);
      tick();
    end
    i_valid = 1'b0;
    chk("idle_no_busy", 90'(o_busy), 90'd0);
    tick();
    do_frame(1, 0, -1, 1'b0);

    do_frame(1, 0, -1, 1'b1);
    do_frame(1, 2, -1, 1'b0);

    repeat (10) tick();
    chk("queue_drained", 90'(q.size()), 90'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/win_gen3x3.md
# win_gen3x3

Streaming 3×3 window generator that sits directly upstream of the convolution core. It accepts a raster-order stream of three-channel 10-bit pixels and buffers the two previous image rows per channel. For every pixel position whose full 3×3 neighbourhood lies inside the image, it presents one 90-bit window bus per channel. The three window buses drive the convolution core's data buses 0–2.

## Interface

Parameters:
- IMG_W, 32, pixels per row (≥3).
- IMG_H, 32, rows per frame (≥3).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  frame start request; honoured only in IDLE.
- i_valid  input  1  i_data is a pixel this cycle.
- i_data  input  30  pixel, one 10-bit value per channel: channel n occupies [10n+9:10n].
- o_busData0  output  90  channel 0 window.
- o_busData1  output  90  channel 1 window.
- o_busData2  output  90  channel 2 window.
- o_valid  output  1  window buses hold a new window this cycle (single-cycle pulse).
- o_last  output  1  with o_valid, marks the last window of the frame.
- o_busy  output  1  high in FILL and RUN.
- o_done  output  1  one-cycle end-of-frame pulse.

## Operation

- Window packing: element k = 3·row + col occupies bits [10k+9:10k].
  - row 0 is the oldest image row (r−2); col 0 is the oldest column (c−2).
  - Element 8 ([89:80]) is the pixel just accepted.
- Counters:
  - col runs 0..IMG_W−1 and row runs 0..IMG_H−1; width is $clog2 of the respective parameter.
  - col wraps to 0 and row increments on each accepted pixel at col = IMG_W−1.
- Line buffers: two per channel, each IMG_W deep and 10 bits wide; they may be shared as 30-bit memories.
  - On an accept at column c, read lb1[c] (row r−1) and lb0[c] (row r−2).
  - Then write lb0[c] ← lb1[c] and lb1[c] ← the new pixel.
  - Buffer contents are not reset. Stale data is never emitted, because of the output gating below.
- Window shift: on accept, each window row shifts one column toward col 0. The new col 2 is {lb0[c], lb1[c], new pixel} for rows 0, 1 and 2.
- Output gating: o_valid rises when the accepted pixel had row ≥ 2 and col ≥ 2. This gives (IMG_W−2)·(IMG_H−2) windows per frame, with no padding.
- FSM states:
  - IDLE: i_valid is ignored. i_start moves to FILL with both counters cleared.
  - FILL: accepts pixels. Moves to RUN on the accept that sets row = 2, col = 0.
  - RUN: accepts pixels. The accept at row = IMG_H−1, col = IMG_W−1 moves to DONE.
  - DONE: lasts exactly one cycle, then IDLE. i_valid is ignored in DONE.
- i_start is ignored outside IDLE.
- i_valid gaps in FILL/RUN:
  - Nothing advances and o_valid is low.
  - The window buses hold their last value.

## Timing

- Reset values:
  - Every output is 0, the FSM is in IDLE, and both counters are 0.
  - The window registers are cleared to 0.
- Reset mid-frame aborts the frame with no o_done, and the next frame requires i_start.
- Latency: a pixel accepted in cycle t produces its window, o_valid and o_last in cycle t+1.
- o_done is asserted in DONE, in the same cycle as the final o_valid and o_last.
- Earliest next frame: i_start in the cycle after DONE (first cycle of IDLE); its first pixel is accepted one cycle later.
- Throughput: one pixel and at most one window per cycle. There is no backpressure, so the consumer must take every o_valid window.
- Simultaneous i_rst and i_start: reset wins.

## Configuration

- WIN_GEN_OUTREG_EN defined:
  - Adds a register stage on o_busData0–2, o_valid, o_last and o_done.
  - All output latencies become t+2.
  - o_done is then asserted one cycle after DONE, aligned with the final o_valid.
  - The extra registers also reset to 0.
- Undefined: outputs come directly from the window registers at latency t+1, as specified above.

## Test plan

- **Basic window contents.**
  - Stimulus: IMG_W = 4, IMG_H = 4; ch0 = p, ch1 = p+100, ch2 = p+200 for pixel index p = 0..15; i_valid held high.
  - Response: exactly 4 o_valid pulses.
  - First window is one cycle after accepting p = 10: ch0 elements k0..8 = 0,1,2,4,5,6,8,9,10, and ch2 element 8 = 210.
- **Final window and end of frame.**
  - Stimulus: same frame as above.
  - Response: the window after p = 15 is 5,6,7,9,10,11,13,14,15, with o_last = 1 and o_done = 1 in the same cycle.
  - o_busy falls on the following cycle.
- **Input gaps.**
  - Stimulus: same frame, with i_valid toggled 1,0,1,0.
  - Response: identical window sequence; o_valid never fires in a gap cycle; buses stable during gaps.
- **Reset mid-frame.**
  - Stimulus: i_rst after p = 9.
  - Response: outputs go to 0 and the FSM to IDLE; no o_done.
  - Pixels without i_start produce nothing.
  - A new frame after i_start produces correct windows; stale line-buffer data never appears.
- **Ignored i_start and back-to-back frames.**
  - Stimulus: i_start pulsed during RUN; then a second frame whose i_start arrives in the first IDLE cycle after DONE.
  - Response: the first frame is unaffected by the mid-frame i_start.
  - The second frame yields 4 correct windows.
- **WIN_GEN_OUTREG_EN defined.**
  - Stimulus: repeat the basic-window-contents scenario.
  - Response: every output is delayed exactly one extra cycle; the values are unchanged.
